// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, icache handshake, redirect and halt.
// Optional FETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] imemaddr,
   input  logic [2:0]  PCsrc,
   input  logic        zero,
   input  logic [31:0] rs_data,
   input  logic        stall,
   input  logic        halt,
   output logic [31:0] instr_id,
   output logic [31:0] npc_id,
   output logic [31:0] pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count,
`endif
   output logic        halted
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t      state;
   logic [31:0] pc_plus4;
   logic [31:0] jtarget;
   logic [31:0] btarget;
   logic [31:0] target;
   logic        redirect;

   assign pc_plus4 = pc + 32'd4;
   assign jtarget  = {npc_id[31:28], instr_id[25:0], 2'b00};
   assign btarget  = npc_id + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      redirect = 1'b0;
      target   = rs_data;
      case (PCsrc)
         3'd1: begin redirect = 1'b1;  target = rs_data; end
         3'd2: begin redirect = 1'b1;  target = jtarget; end
         3'd3: begin redirect = zero;  target = btarget; end
         3'd4: begin redirect = !zero; target = btarget; end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= RUN;
         pc       <= PC_INIT;
         instr_id <= 32'd0;
         npc_id   <= 32'd0;
      end else if (state == RUN) begin
         if (halt) begin
            state <= HALTED;
         end else if (stall) begin
            // hold; a pending redirect is seen again next cycle from the held instr_id
         end else if (redirect) begin
            pc       <= target;
            instr_id <= 32'd0;
            npc_id   <= 32'd0;
         end else if (ihit) begin
            pc       <= pc_plus4;
            instr_id <= imemload;
            npc_id   <= pc_plus4;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_count <= 32'd0;
         stall_count <= 32'd0;
      end else if (state == RUN) begin
         if (!halt && !stall && !redirect && ihit)
            fetch_count <= fetch_count + 32'd1;
         if (stall || (iREN && !ihit))
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

   assign iREN     = (state == RUN);
   assign halted   = (state == HALTED);
   assign imemaddr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven vectors plus a hand-written halt-hold sequence.
// A second instance with PC_INIT = 32'hFFFF_FFFC exercises PC wrap.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST, ihit, zero, stall, halt;
   logic [31:0] imemload, rs_data;
   logic [2:0]  PCsrc;
   logic        iREN, halted;
   logic [31:0] imemaddr, instr_id, npc_id, pc;
   logic        w_iREN, w_halted;
   logic [31:0] w_imemaddr, w_instr_id, w_npc_id, w_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   fetch_unit u_dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
      .imemaddr(imemaddr), .PCsrc(PCsrc), .zero(zero), .rs_data(rs_data),
      .stall(stall), .halt(halt), .instr_id(instr_id), .npc_id(npc_id), .pc(pc),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count(fetch_count), .stall_count(stall_count),
`endif
      .halted(halted)
   );

   fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) u_wrap (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(w_iREN),
      .imemaddr(w_imemaddr), .PCsrc(PCsrc), .zero(zero), .rs_data(rs_data),
      .stall(stall), .halt(halt), .instr_id(w_instr_id), .npc_id(w_npc_id), .pc(w_pc),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count(w_fetch_count), .stall_count(w_stall_count),
`endif
      .halted(w_halted)
   );

   typedef struct {
      logic        rst, ihit, zero, stall, halt;
      logic [31:0] imem, rs;
      logic [2:0]  pcsrc;
      logic [31:0] e_pc, e_instr, e_npc;
      logic        e_iren, e_halted;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] A   = 32'h1111_0001, B = 32'h2222_0002, C = 32'h3333_0003;
   localparam logic [31:0] D   = 32'h4444_0004, E = 32'h5555_0005, F = 32'h6666_0006;
   localparam logic [31:0] G   = 32'h7777_0007, W = 32'h0000_0008, X = 32'hABCD_0009;
   localparam logic [31:0] BEQ = 32'h1000_FFFF, J = 32'h0800_0123, BNE = 32'h1400_0002;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   task automatic add(input logic rst, input logic ih, input logic [31:0] im,
                      input logic [2:0] ps, input logic z, input logic [31:0] rs,
                      input logic st, input logic h,
                      input logic [31:0] ep, input logic [31:0] ei, input logic [31:0] en,
                      input logic eren, input logic eh);
      vec_t v;
      v.rst = rst; v.ihit = ih; v.imem = im; v.pcsrc = ps; v.zero = z; v.rs = rs;
      v.stall = st; v.halt = h; v.e_pc = ep; v.e_instr = ei; v.e_npc = en;
      v.e_iren = eren; v.e_halted = eh;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic ih, input logic [31:0] im,
                        input logic [2:0] ps, input logic z, input logic [31:0] rs,
                        input logic st, input logic h);
      @(negedge CLK);
      RST = rst; ihit = ih; imemload = im; PCsrc = ps; zero = z; rs_data = rs;
      stall = st; halt = h;
      @(posedge CLK);
      #1;
   endtask

   task automatic apply(input int i);
      string tag;
      drive(vecs[i].rst, vecs[i].ihit, vecs[i].imem, vecs[i].pcsrc, vecs[i].zero,
            vecs[i].rs, vecs[i].stall, vecs[i].halt);
      tag = $sformatf("v%0d", i);
      check({tag, ".pc"},       pc,       vecs[i].e_pc);
      check({tag, ".imemaddr"}, imemaddr, vecs[i].e_pc);
      check({tag, ".instr_id"}, instr_id, vecs[i].e_instr);
      check({tag, ".npc_id"},   npc_id,   vecs[i].e_npc);
      check({tag, ".iREN"},     {31'd0, iREN},   {31'd0, vecs[i].e_iren});
      check({tag, ".halted"},   {31'd0, halted}, {31'd0, vecs[i].e_halted});
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; imemload = '0; PCsrc = '0; zero = 1'b0;
      rs_data = '0; stall = 1'b0; halt = 1'b0;

      //   rst ihit imem  ps  z  rs        st h   pc            instr  npc           iren halted
      add(1, 1, JUNK, 0, 0, 0,         1, 0,  32'h0,        0,     32'h0,        1, 0); // 0 reset beats stall
      add(0, 1, A,    0, 0, 0,         0, 0,  32'h4,        A,     32'h4,        1, 0); // 1
      add(0, 1, B,    0, 0, 0,         0, 0,  32'h8,        B,     32'h8,        1, 0); // 2
      add(0, 1, C,    0, 0, 0,         0, 0,  32'hC,        C,     32'hC,        1, 0); // 3
      for (int k = 0; k < 3; k++)
         add(0, 0, JUNK, 0, 0, 0,      0, 0,  32'hC,        C,     32'hC,        1, 0); // 4-6 miss
      add(0, 1, D,    0, 0, 0,         0, 0,  32'h10,       D,     32'h10,       1, 0); // 7
      add(0, 1, E,    0, 0, 0,         0, 0,  32'h14,       E,     32'h14,       1, 0); // 8
      add(0, 1, F,    0, 0, 0,         0, 0,  32'h18,       F,     32'h18,       1, 0); // 9
      add(0, 1, G,    0, 0, 0,         0, 0,  32'h1C,       G,     32'h1C,       1, 0); // 10
      add(0, 1, BEQ,  0, 0, 0,         0, 0,  32'h20,       BEQ,   32'h20,       1, 0); // 11
      add(0, 1, JUNK, 3, 1, 0,         0, 0,  32'h1C,       0,     32'h0,        1, 0); // 12 BEQ taken
      add(0, 1, BEQ,  0, 0, 0,         0, 0,  32'h20,       BEQ,   32'h20,       1, 0); // 13
      add(0, 1, W,    3, 0, 0,         0, 0,  32'h24,       W,     32'h24,       1, 0); // 14 BEQ not taken
      add(0, 1, JUNK, 1, 0, 32'h400,   1, 0,  32'h24,       W,     32'h24,       1, 0); // 15 JR stalled
      add(0, 1, JUNK, 1, 0, 32'h400,   1, 0,  32'h24,       W,     32'h24,       1, 0); // 16
      add(0, 1, JUNK, 1, 0, 32'h400,   0, 0,  32'h400,      0,     32'h0,        1, 0); // 17 JR taken
      add(0, 1, J,    5, 1, 32'h800,   0, 0,  32'h404,      J,     32'h404,      1, 0); // 18 PCsrc 5 = seq
      add(0, 1, JUNK, 2, 0, 0,         0, 1,  32'h404,      J,     32'h404,      0, 1); // 19 halt beats J
      add(1, 1, JUNK, 2, 0, 0,         1, 1,  32'h0,        0,     32'h0,        1, 0); // 20 reset out of HALTED
      add(0, 1, J,    0, 0, 0,         0, 0,  32'h4,        J,     32'h4,        1, 0); // 21
      add(0, 1, JUNK, 2, 0, 0,         0, 0,  32'h48C,      0,     32'h0,        1, 0); // 22 J taken
      add(0, 1, BNE,  0, 0, 0,         0, 0,  32'h490,      BNE,   32'h490,      1, 0); // 23
      add(0, 1, JUNK, 4, 0, 0,         0, 0,  32'h498,      0,     32'h0,        1, 0); // 24 BNE taken
      add(0, 1, X,    4, 1, 0,         0, 0,  32'h49C,      X,     32'h49C,      1, 0); // 25 BNE not taken

      for (int i = 0; i < 20; i++) begin
         apply(i);
         if (i == 0) check("wrap.reset_pc", w_pc, 32'hFFFF_FFFC);
         if (i == 1) begin
            check("wrap.pc",  w_pc,     32'h0);
            check("wrap.npc", w_npc_id, 32'h0);
            check("wrap.instr", w_instr_id, A);
         end
`ifdef FETCH_PERF_CNT_EN
         if (i == 6) begin
            check("perf.stall_after_miss", stall_count, 32'd3);
            check("perf.fetch_after_miss", fetch_count, 32'd3);
         end
`endif
      end

      // HALTED must hold everything for 10 cycles despite ihit and a jump request.
      for (int k = 0; k < 10; k++) begin
         drive(0, 1, JUNK, 2, 1, 32'h900, 0, 0);
         check($sformatf("hold%0d.pc", k),       pc,       32'h404);
         check($sformatf("hold%0d.instr", k),    instr_id, J);
         check($sformatf("hold%0d.npc", k),      npc_id,   32'h404);
         check($sformatf("hold%0d.iREN", k),     {31'd0, iREN},   32'd0);
         check($sformatf("hold%0d.halted", k),   {31'd0, halted}, 32'd1);
      end

      for (int i = 20; i < vecs.size(); i++) apply(i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
